// File: rtl/mmio_arbiter_pkg.sv
// Shared definitions for the two-master MMIO sequencer: widths, defaults, states, payload.
package mmio_arbiter_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PAGE_W = 7;

    // Page of the slow-clock terminal and the default wait budgets.
    localparam logic [PAGE_W-1:0] MMIO_SLOW_PAGE = 7'h03;
    localparam int unsigned       MMIO_FAST_WAIT = 0;
    localparam int unsigned       MMIO_SLOW_WAIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mmio_state_e;

    // One latched master request.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mmio_req_t;

    // True when the address falls in the given page (addr[14:8]).
    function automatic logic is_page(input logic [ADDR_W-1:0] a,
                                     input logic [PAGE_W-1:0] page);
        return a[ADDR_W-1 -: PAGE_W] == page;
    endfunction

endpackage

// File: rtl/mmio_arbiter_rr_arb.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the master not granted last.
module mmio_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // One-hot grant; last_grant==1 means master 1 won last time, so master 0 wins a tie.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last_grant);
        gnt[1] = req[1] & (~req[0] | ~last_grant);
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master sequencer for the shared peripheral bus: arbitrate, strobe, wait, acknowledge.
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int unsigned       FAST_WAIT = MMIO_FAST_WAIT,
    parameter int unsigned       SLOW_WAIT = MMIO_SLOW_WAIT,
    parameter logic [PAGE_W-1:0] SLOW_PAGE = MMIO_SLOW_PAGE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              re,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read
);

    mmio_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mmio_req_t         txn_q, txn_d;
    logic              gnt_idx_q, gnt_idx_d;
    logic              last_grant_q, last_grant_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;

    logic [1:0]        arb_gnt_c;
    mmio_req_t         m0_pkt_c, m1_pkt_c, sel_pkt_c;
    logic              slow_c;
    logic              hold_c;

    assign m0_pkt_c  = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
    assign m1_pkt_c  = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
    assign sel_pkt_c = arb_gnt_c[1] ? m1_pkt_c : m0_pkt_c;
    assign slow_c    = is_page(txn_q.addr, SLOW_PAGE);

    mmio_rr_arb u_rr_arb (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt_c)
    );

    // State, counter, latched request and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            txn_q        <= '0;
            gnt_idx_q    <= 1'b0;
            last_grant_q <= 1'b1;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            txn_q        <= txn_d;
            gnt_idx_q    <= gnt_idx_d;
            last_grant_q <= last_grant_d;
            re_q         <= re_d;
            we_q         <= we_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
        end
    end

    // Next state and next output values; strobes are computed one cycle ahead so they are registered.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        txn_d        = txn_q;
        gnt_idx_d    = gnt_idx_q;
        last_grant_d = last_grant_q;
        re_d         = 1'b0;
        we_d         = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        hold_c       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_gnt_c != 2'b00) begin
                    gnt_idx_d = arb_gnt_c[1];
                    txn_d     = sel_pkt_c;
                    re_d      = ~sel_pkt_c.we;
                    we_d      = sel_pkt_c.we;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = slow_c ? CNT_W'(SLOW_WAIT) : CNT_W'(FAST_WAIT);
                hold_c  = slow_c && (cnt_d != '0);
                re_d    = hold_c & ~txn_q.we;
                we_d    = hold_c & txn_q.we;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (!txn_q.we) begin
                        if (gnt_idx_q) m1_rdata_d = data_read;
                        else           m0_rdata_d = data_read;
                    end
                    m0_ack_d = ~gnt_idx_q;
                    m1_ack_d = gnt_idx_q;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    // Slow page keeps the strobe up until the final wait cycle.
                    hold_c = slow_c && (cnt_d != '0);
                    re_d   = hold_c & ~txn_q.we;
                    we_d   = hold_c & txn_q.we;
                end
            end
            ST_DONE: begin
                last_grant_d = gnt_idx_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign re         = re_q;
    assign we         = we_q;
    assign addr       = txn_q.addr;
    assign data_write = txn_q.wdata;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;
    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: latency, slow page hold, contention, dropped request, reset.
module tb_mmio_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [14:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        re, we;
    logic [14:0] addr;
    logic [7:0]  data_write;
    logic [7:0]  data_read = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    logic both_seen = 1'b0;

    mmio_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_rdata   (m0_rdata),
        .m0_ack     (m0_ack),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_rdata   (m1_rdata),
        .m1_ack     (m1_ack),
        .re         (re),
        .we         (we),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read)
    );

    always #5 clk = ~clk;

    // Peripheral stand-in: registered read data, value = addr[7:0] ^ 8'hA0.
    always @(posedge clk) begin
        if (re) data_read <= addr[7:0] ^ 8'hA0;
    end

    // Remember any cycle where both strobes are up.
    always @(negedge clk) begin
        if (re && we) both_seen <= 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_re"},    re,         0);
        check_val({tag, "_we"},    we,         0);
        check_val({tag, "_addr"},  addr,       0);
        check_val({tag, "_wdata"}, data_write, 0);
        check_val({tag, "_r0"},    m0_rdata,   0);
        check_val({tag, "_r1"},    m1_rdata,   0);
        check_val({tag, "_ack0"},  m0_ack,     0);
        check_val({tag, "_ack1"},  m1_ack,     0);
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        step();
        step();
        check_all_zero("rst");
        rst_n = 1'b1;

        // Read, normal page: re in cycle 1 only, ack in cycle 3, data A5.
        m0_req = 1; m0_we = 0; m0_addr = 15'h0005;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_val($sformatf("rd_re_c%0d", k), re, (k == 1));
            check_val($sformatf("rd_we_c%0d", k), we, 0);
            check_val($sformatf("rd_ack0_c%0d", k), m0_ack, (k == 3));
            if (k == 1) check_val("rd_addr", addr, 15'h0005);
            if (k == 3) begin
                check_val("rd_data", m0_rdata, 8'hA5);
                m0_req = 0;
            end
        end
        check_val("rd_data_hold", m0_rdata, 8'hA5);

        // Write, slow page: we high cycles 1..9, ack in cycle 11, rdata untouched.
        m1_req = 1; m1_we = 1; m1_addr = 15'h0302; m1_wdata = 8'h41;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_val($sformatf("wr_we_c%0d", k), we, (k <= 9));
            check_val($sformatf("wr_re_c%0d", k), re, 0);
            check_val($sformatf("wr_ack1_c%0d", k), m1_ack, (k == 11));
            if (k <= 9) check_val($sformatf("wr_dw_c%0d", k), data_write, 8'h41);
            if (k == 11) m1_req = 0;
        end
        check_val("wr_r1_unchanged", m1_rdata, 8'h00);

        // Contention from reset: grants 0,1,0,1 with acks 4 cycles apart.
        rst_n = 1'b0;
        #1;
        m0_req = 1; m0_we = 0; m0_addr = 15'h0011;
        m1_req = 1; m1_we = 0; m1_addr = 15'h0022;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check_val($sformatf("ct_ack0_c%0d", k), m0_ack, (k == 3 || k == 11));
            check_val($sformatf("ct_ack1_c%0d", k), m1_ack, (k == 7 || k == 15));
            if (k == 1) check_val("ct_addr_c1", addr, 15'h0011);
            if (k == 5) check_val("ct_addr_c5", addr, 15'h0022);
            if (k == 9) check_val("ct_addr_c9", addr, 15'h0011);
            if (k == 4) check_val("ct_r0", m0_rdata, 8'hB1);
            if (k == 8) check_val("ct_r1", m1_rdata, 8'h82);
            if (k == 15) begin
                m0_req = 0;
                m1_req = 0;
            end
        end
        check_val("ct_no_overlap", both_seen, 0);

        // m0 drops req mid-transaction; pending m1 is served next.
        m0_req = 1; m0_we = 0; m0_addr = 15'h0033;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                m1_req = 1; m1_we = 0; m1_addr = 15'h0044;
            end
            if (k == 2) m0_req = 0;
            check_val($sformatf("dr_ack0_c%0d", k), m0_ack, (k == 3));
            check_val($sformatf("dr_ack1_c%0d", k), m1_ack, (k == 7));
            if (k == 3) check_val("dr_r0", m0_rdata, 8'h93);
            if (k == 5) begin
                check_val("dr_addr_c5", addr, 15'h0044);
                check_val("dr_re_c5", re, 1);
            end
            if (k == 7) begin
                check_val("dr_r1", m1_rdata, 8'hE4);
                m1_req = 0;
            end
        end

        // Reset during a slow-page read: immediate clear, no ack, clean restart.
        m1_req = 1; m1_we = 0; m1_addr = 15'h0301;
        for (int k = 1; k <= 4; k++) step();
        check_val("rw_re_held", re, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rw_async");
        step();
        step();
        check_val("rw_noack1", m1_ack, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_val($sformatf("rw_ack1_c%0d", k), m1_ack, (k == 11));
            check_val($sformatf("rw_ack0_c%0d", k), m0_ack, 0);
            if (k == 9)  check_val("rw_re_c9", re, 1);
            if (k == 10) check_val("rw_re_c10", re, 0);
            if (k == 11) begin
                check_val("rw_r1", m1_rdata, 8'hA1);
                m1_req = 0;
            end
        end
        check_val("all_no_overlap", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
